// File: rtl/ctrl_seq_pkg.sv
// Shared types and constants for the control sequencer: state encoding,
// ALU operation codes and B-operand select codes.
package ctrl_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_LOAD  = 3'd2,
      S_TEST  = 3'd3,
      S_OP_A  = 3'd4,
      S_OP_B  = 3'd5,
      S_DONE  = 3'd6
   } state_e;

   localparam logic [1:0] ALU_PASS = 2'd0;
   localparam logic [1:0] ALU_OP1  = 2'd1;
   localparam logic [1:0] ALU_OP2  = 2'd2;
   localparam logic [1:0] ALU_FIN  = 2'd3;

   localparam int unsigned BSEL_REG  = 0;
   localparam int unsigned BSEL_DATA = 1;
   localparam int unsigned BSEL_ALU  = 2;

endpackage

// File: rtl/ctrl_seq_cnt.sv
// Iteration down-counter: parallel load, decrement, and terminal flags used
// by the sequencer to pick the next state.
module ctrl_seq_cnt #(
   parameter int ITERW = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             dec,
   input  logic [ITERW-1:0] load_val,
   output logic [ITERW-1:0] cnt,
   output logic             is_one,
   output logic             is_zero
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign is_zero = (cnt == '0);
   assign is_one  = (cnt == ITERW'(1));

endmodule

// File: rtl/ctrl_seq.sv
// Control sequencer for the register-file / ALU datapath: clear, load,
// equality test, N compute iterations, repeat until the datapath reports eq.
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  IDLE    | waiting for start; iter_cnt captured on start
//  CLEAR   | synchronous clear of every datapath register
//  LOAD    | external data written to all registers, counter reloaded
//  TEST    | eq sampled: DONE on match, else iterate or re-load
//  OP_A    | first half of a compute iteration
//  OP_B    | second half; result written to the last register
//  DONE    | finished; sticky or one-cycle depending on STICKY_DONE
module ctrl_seq
   import ctrl_seq_pkg::*;
#(
   parameter int NREG        = 3,
   parameter int SELW        = 2,
   parameter int ITERW       = 4,
   parameter bit STICKY_DONE = 1'b1
) (
   input  logic             clk,
   input  logic             resControl_n,
   input  logic             start,
   input  logic [ITERW-1:0] iter_cnt,
   input  logic             eq,
   output logic [NREG-1:0]  wen,
   output logic             wsel,
   output logic [SELW-1:0]  asel,
   output logic [SELW-1:0]  bsel,
   output logic             datasel,
   output logic [1:0]       alusel,
   output logic [NREG-1:0]  resReg,
   output logic             busy,
   output logic             done
);

   state_e           state;
   logic [ITERW-1:0] iter_q;
   logic             first_done;
   logic [ITERW-1:0] cnt;
   logic             cnt_one;
   logic             cnt_zero;

   ctrl_seq_cnt #(.ITERW(ITERW)) u_cnt (
      .clk      (clk),
      .rst_n    (resControl_n),
      .load     (state == S_LOAD),
      .dec      (state == S_OP_B),
      .load_val (iter_q),
      .cnt      (cnt),
      .is_one   (cnt_one),
      .is_zero  (cnt_zero)
   );

   always_ff @(posedge clk or negedge resControl_n) begin
      if (!resControl_n) begin
         state      <= S_IDLE;
         iter_q     <= '0;
         first_done <= 1'b0;
      end else begin
         first_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  iter_q <= iter_cnt;
                  state  <= S_CLEAR;
               end
            end
            S_CLEAR: state <= S_LOAD;
            S_LOAD:  state <= S_TEST;
            S_TEST: begin
               if (eq) begin
                  state      <= S_DONE;
                  first_done <= 1'b1;
               end else if (!cnt_zero) begin
                  state <= S_OP_A;
               end else begin
                  state <= S_LOAD;
               end
            end
            S_OP_A:  state <= S_OP_B;
            S_OP_B:  state <= cnt_one ? S_LOAD : S_OP_A;
            S_DONE: begin
               if (!STICKY_DONE) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Decoded straight from the state register so an async reset clears
   // every output without waiting for a clock edge.
   always_comb begin
      wen     = '0;
      wsel    = 1'b0;
      asel    = '0;
      bsel    = '0;
      datasel = 1'b0;
      alusel  = ALU_PASS;
      resReg  = '0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state)
         S_CLEAR: begin
            resReg = '1;
            busy   = 1'b1;
         end
         S_LOAD: begin
            wen     = '1;
            datasel = 1'b1;
            bsel    = SELW'(BSEL_DATA);
            busy    = 1'b1;
         end
         S_TEST: begin
            wsel = 1'b1;
            bsel = SELW'(BSEL_DATA);
            busy = 1'b1;
         end
         S_OP_A: begin
            bsel   = SELW'(BSEL_ALU);
            alusel = ALU_OP1;
            busy   = 1'b1;
         end
         S_OP_B: begin
            bsel         = SELW'(BSEL_ALU);
            alusel       = ALU_OP2;
            wen[NREG-1]  = 1'b1;
            busy         = 1'b1;
         end
         S_DONE: begin
            done   = 1'b1;
            bsel   = SELW'(BSEL_ALU);
            alusel = ALU_FIN;
            if (first_done) wen = '1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: a sticky-done and a pulse-done instance share stimulus
// and are compared against a pass-position model of the sequence.
module tb_ctrl_seq;

   logic       clk = 1'b0;
   logic       resControl_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] iter_cnt = '0;
   logic       eq = 1'b0;

   logic [2:0] wen_s, wen_p, resreg_s, resreg_p;
   logic       wsel_s, wsel_p, datasel_s, datasel_p;
   logic [1:0] asel_s, asel_p, bsel_s, bsel_p, alusel_s, alusel_p;
   logic       busy_s, busy_p, done_s, done_p;
   logic [15:0] out_s, out_p;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ctrl_seq #(.NREG(3), .SELW(2), .ITERW(4), .STICKY_DONE(1'b1)) u_sticky (
      .clk(clk), .resControl_n(resControl_n), .start(start), .iter_cnt(iter_cnt), .eq(eq),
      .wen(wen_s), .wsel(wsel_s), .asel(asel_s), .bsel(bsel_s), .datasel(datasel_s),
      .alusel(alusel_s), .resReg(resreg_s), .busy(busy_s), .done(done_s));

   ctrl_seq #(.NREG(3), .SELW(2), .ITERW(4), .STICKY_DONE(1'b0)) u_pulse (
      .clk(clk), .resControl_n(resControl_n), .start(start), .iter_cnt(iter_cnt), .eq(eq),
      .wen(wen_p), .wsel(wsel_p), .asel(asel_p), .bsel(bsel_p), .datasel(datasel_p),
      .alusel(alusel_p), .resReg(resreg_p), .busy(busy_p), .done(done_p));

   assign out_s = {wen_s, wsel_s, asel_s, bsel_s, datasel_s, alusel_s, resreg_s, busy_s, done_s};
   assign out_p = {wen_p, wsel_p, asel_p, bsel_p, datasel_p, alusel_p, resreg_p, busy_p, done_p};

   // Model: phase plus position inside a pass (0 = LOAD, 1 = TEST,
   // 2..2n+1 = alternating first/second half of each iteration).
   localparam int PH_IDLE = 0, PH_CLEAR = 1, PH_PASS = 2, PH_DONE = 3;
   int m_ph[2], m_pos[2], m_n[2];
   bit m_first[2];

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_ph[i] = PH_IDLE; m_pos[i] = 0; m_n[i] = 0; m_first[i] = 1'b0;
      end
   endfunction

   function automatic void model_step(int i);
      if (!resControl_n) begin
         m_ph[i] = PH_IDLE; m_pos[i] = 0; m_n[i] = 0; m_first[i] = 1'b0;
         return;
      end
      case (m_ph[i])
         PH_IDLE: if (start) begin m_n[i] = int'(iter_cnt); m_ph[i] = PH_CLEAR; end
         PH_CLEAR: begin m_ph[i] = PH_PASS; m_pos[i] = 0; end
         PH_PASS: begin
            if (m_pos[i] == 0) m_pos[i] = 1;
            else if (m_pos[i] == 1) begin
               if (eq) begin m_ph[i] = PH_DONE; m_first[i] = 1'b1; end
               else if (m_n[i] == 0) m_pos[i] = 0;
               else m_pos[i] = 2;
            end else if (m_pos[i] == 2 * m_n[i] + 1) m_pos[i] = 0;
            else m_pos[i] = m_pos[i] + 1;
         end
         default: begin
            m_first[i] = 1'b0;
            if (i == 1) m_ph[i] = PH_IDLE;
         end
      endcase
   endfunction

   function automatic logic [15:0] exp_out(int i);
      logic [2:0] w = '0, r = '0;
      logic ws = 1'b0, ds = 1'b0, bz = 1'b0, dn = 1'b0;
      logic [1:0] b = '0, a = '0;
      case (m_ph[i])
         PH_CLEAR: begin r = 3'b111; bz = 1'b1; end
         PH_PASS: begin
            bz = 1'b1;
            if (m_pos[i] == 0) begin w = 3'b111; ds = 1'b1; b = 2'd1; end
            else if (m_pos[i] == 1) begin ws = 1'b1; b = 2'd1; end
            else if (m_pos[i] % 2 == 0) begin b = 2'd2; a = 2'd1; end
            else begin b = 2'd2; a = 2'd2; w = 3'b100; end
         end
         PH_DONE: begin dn = 1'b1; b = 2'd2; a = 2'd3; w = m_first[i] ? 3'b111 : 3'b000; end
         default: ;
      endcase
      return {w, ws, 2'b00, b, ds, a, r, bz, dn};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
   endtask

   task automatic do_reset();
      resControl_n = 1'b0;
      start = 1'b0; eq = 1'b0;
      model_reset();
      #3;
      resControl_n = 1'b1;
   endtask

   task automatic test_reset();
      resControl_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (out_s !== 16'h0 || out_p !== 16'h0) begin
         errors++; $display("FAIL reset_outputs: got %h/%h required 0000/0000", out_s, out_p);
      end
      tick(); tick();
      resControl_n = 1'b1;
      tick();
      checks++;
      if (busy_s !== 1'b0 || busy_p !== 1'b0 || out_s !== exp_out(0)) begin
         errors++; $display("FAIL reset_idle: busy %b/%b out %h required busy 0 out %h", busy_s, busy_p, out_s, exp_out(0));
      end
   endtask

   task automatic test_reset_mid_opb();
      do_reset();
      iter_cnt = 4'd5; eq = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 12 && !(m_ph[0] == PH_PASS && m_pos[0] >= 2 && m_pos[0] % 2 == 1); c++) tick();
      checks++;
      if (wen_s !== 3'b100) begin
         errors++; $display("FAIL mid_opb_reached: wen %b required 100", wen_s);
      end
      resControl_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (out_s !== 16'h0 || out_p !== 16'h0) begin
         errors++; $display("FAIL reset_mid_opb: got %h/%h required 0000/0000", out_s, out_p);
      end
      #2 resControl_n = 1'b1;
      tick();
      checks++;
      if (busy_s !== 1'b0 || out_s !== 16'h0 || out_p !== 16'h0) begin
         errors++; $display("FAIL after_reset_idle: busy %b out %h/%h required idle zeros", busy_s, out_s, out_p);
      end
   endtask

   task automatic test_no_iter();
      do_reset();
      iter_cnt = 4'd0; eq = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int j = 1; j <= 6; j++) begin
         checks++;
         if (out_s !== exp_out(0) || out_p !== exp_out(1)) begin
            errors++; $display("FAIL no_iter_model k+%0d: got %h/%h required %h/%h", j, out_s, out_p, exp_out(0), exp_out(1));
         end
         checks++;
         case (j)
            1: if (resreg_s !== 3'b111) begin errors++; $display("FAIL no_iter_clear: resReg %b required 111", resreg_s); end
            2: if (wen_s !== 3'b111 || datasel_s !== 1'b1) begin errors++; $display("FAIL no_iter_load: wen %b datasel %b required 111 1", wen_s, datasel_s); end
            3: if (done_s !== 1'b0 || wen_s !== 3'b000) begin errors++; $display("FAIL no_iter_test: done %b wen %b required 0 000", done_s, wen_s); end
            4: if (done_s !== 1'b1 || wen_s !== 3'b111 || done_p !== 1'b1) begin errors++; $display("FAIL no_iter_done: done %b/%b wen %b required 1/1 111", done_s, done_p, wen_s); end
            default: if (done_s !== 1'b1 || wen_s !== 3'b000 || done_p !== 1'b0) begin errors++; $display("FAIL no_iter_after: done %b/%b wen %b required 1/0 000", done_s, done_p, wen_s); end
         endcase
         tick();
      end
   endtask

   task automatic test_two_iter();
      do_reset();
      iter_cnt = 4'd2; eq = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int j = 1; j <= 11; j++) begin
         checks++;
         if (out_s !== exp_out(0) || out_p !== exp_out(1)) begin
            errors++; $display("FAIL two_iter_model k+%0d: got %h/%h required %h/%h", j, out_s, out_p, exp_out(0), exp_out(1));
         end
         if (j >= 4 && j <= 7) begin
            checks++;
            if (bsel_s !== 2'd2 || wen_s !== ((j % 2 == 1) ? 3'b100 : 3'b000)) begin
               errors++; $display("FAIL two_iter_op k+%0d: bsel %0d wen %b", j, bsel_s, wen_s);
            end
         end
         if (j == 8) begin
            checks++;
            if (datasel_s !== 1'b1) begin errors++; $display("FAIL two_iter_reload: datasel %b required 1", datasel_s); end
         end
         if (j == 10) begin
            checks++;
            if (done_s !== 1'b1) begin errors++; $display("FAIL two_iter_done: done %b required 1", done_s); end
         end
         eq = (j >= 4);
         tick();
      end
   endtask

   task automatic test_pulse_done();
      int c;
      do_reset();
      iter_cnt = 4'd1; eq = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (c = 0; c < 10 && !done_p; c++) tick();
      checks++;
      if (done_p !== 1'b1) begin errors++; $display("FAIL pulse_timeout: done %b required 1", done_p); end
      tick();
      checks++;
      if (done_p !== 1'b0 || busy_p !== 1'b0 || done_s !== 1'b1) begin
         errors++; $display("FAIL pulse_width: done %b/%b busy %b required 1/0 0", done_s, done_p, busy_p);
      end
      start = 1'b1; eq = 1'b0;
      tick();
      start = 1'b0;
      checks++;
      if (resreg_p !== 3'b111 || out_p !== exp_out(1) || out_s !== exp_out(0)) begin
         errors++; $display("FAIL pulse_restart: resReg %b out %h required 111 %h", resreg_p, out_p, exp_out(1));
      end
   endtask

   task automatic test_start_during_run();
      int loads, pulses;
      do_reset();
      iter_cnt = 4'd3; eq = 1'b0; start = 1'b1;
      tick();
      start = 1'b0; iter_cnt = 4'd9;
      tick(); tick(); tick();
      start = 1'b1; iter_cnt = 4'd7;
      loads = 1; pulses = 0;
      for (int c = 0; c < 40 && loads < 3; c++) begin
         tick();
         start = 1'b0;
         checks++;
         if (out_s !== exp_out(0) || out_p !== exp_out(1)) begin
            errors++; $display("FAIL restart_model: got %h/%h required %h/%h", out_s, out_p, exp_out(0), exp_out(1));
         end
         if (datasel_s) begin
            loads++;
            checks++;
            if (pulses !== 3) begin errors++; $display("FAIL captured_iter: pulses %0d required 3", pulses); end
            pulses = 0;
         end else if (wen_s === 3'b100) pulses++;
      end
      checks++;
      if (loads !== 3) begin errors++; $display("FAIL restart_timeout: loads %0d required 3", loads); end
   endtask

   task automatic test_full_count();
      int loads, pulses;
      do_reset();
      iter_cnt = 4'd15; eq = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      loads = 0; pulses = 0;
      for (int c = 0; c < 60 && loads < 2; c++) begin
         tick();
         if (datasel_s) loads++;
         else if (loads == 1 && wen_s === 3'b100) pulses++;
      end
      checks++;
      if (loads !== 2 || pulses !== 15) begin
         errors++; $display("FAIL full_count: loads %0d pulses %0d required 2 15", loads, pulses);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         start = ($urandom_range(0, 3) == 0);
         iter_cnt = ($urandom_range(0, 7) == 0) ? 4'(15) : 4'($urandom_range(0, 3));
         eq = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 59) == 0) begin
            resControl_n = 1'b0;
            model_reset();
            #2;
            checks++;
            if (out_s !== 16'h0 || out_p !== 16'h0) begin
               errors++; $display("FAIL random_reset: got %h/%h required 0000/0000", out_s, out_p);
            end
            #2 resControl_n = 1'b1;
         end
         tick();
         checks++;
         if (out_s !== exp_out(0) || out_p !== exp_out(1)) begin
            errors++; $display("FAIL random_model cycle %0d: got %h/%h required %h/%h", c, out_s, out_p, exp_out(0), exp_out(1));
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_reset_mid_opb();
      test_no_iter();
      test_two_iter();
      test_pulse_done();
      test_start_during_run();
      test_full_count();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Parametrised control sequencer for the register-file / ALU datapath. It drives the write-enable, operand-select, data-select, ALU-op and register-clear lines through the fixed sequence: clear, load, equality test, N compute iterations, repeat. It adds four things to the earlier fixed controller: a generic register count, a run-time iteration count, a start/busy/done handshake and a selectable done behaviour. It sits between the top-level command logic and the datapath, and consumes the datapath `eq` flag.

## Interface
- `NREG`, 3: number of datapath registers; sets the `wen`/`resReg` width.
- `SELW`, 2: operand-select width for `asel`/`bsel`; must be ≥ 2.
- `ITERW`, 4: iteration-count width.
- `STICKY_DONE`, 1: 1 = DONE holds until reset; 0 = DONE lasts 1 cycle, then IDLE.

Ports:
- `clk` in 1: single clock, rising edge.
- `resControl_n` in 1: reset, asynchronous, active-low.
- `start` in 1: run request, sampled in IDLE only.
- `iter_cnt` in ITERW: compute iterations per pass, captured with `start`.
- `eq` in 1: datapath equality flag, sampled in TEST.
- `wen` out NREG: per-register write enable.
- `wsel` out 1: write-source select.
- `asel` out SELW: A-operand select; always 0 in this revision.
- `bsel` out SELW: B-operand select.
- `datasel` out 1: 1 = external data onto write bus.
- `alusel` out 2: ALU operation.
- `resReg` out NREG: per-register synchronous clear request.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: high in DONE.

## Operation
- States: IDLE, CLEAR, LOAD, TEST, OP_A, OP_B, DONE.
- Outputs are Moore, decoded from the state register plus the `first_done` flag. Any signal not listed for a state is 0.
- IDLE
  - All outputs 0.
  - `start`=1: capture `iter_cnt` into `iter_q`, go to CLEAR.
- CLEAR: `resReg` = all ones; go to LOAD.
- LOAD
  - `wen` = all ones, `datasel`=1, `bsel`=1.
  - Load down-counter `cnt` ← `iter_q`; go to TEST.
- TEST: `wsel`=1, `bsel`=1. Priority:
  - `eq`=1: go to DONE.
  - else `cnt`≠0: go to OP_A.
  - else: go to LOAD.
- OP_A: `bsel`=2, `alusel`=1; go to OP_B.
- OP_B
  - `bsel`=2, `alusel`=2, `wen` = only bit NREG-1 set.
  - `cnt` ← `cnt`−1.
  - If `cnt` was 1: go to LOAD; else go to OP_A.
- DONE
  - `done`=1, `bsel`=2, `alusel`=3.
  - `wen` = all ones on the entry cycle only (`first_done`=1), 0 after.
  - STICKY_DONE=1: stay in DONE until reset.
  - STICKY_DONE=0: go to IDLE next cycle.
- Boundary rules:
  - `start` outside IDLE is ignored; `iter_cnt` changes after capture have no effect.
  - `iter_q`=0: TEST with `eq`=0 returns straight to LOAD, so the block re-loads until `eq`.
  - `iter_q`=2^ITERW−1: full count is executed, with no wrap.
  - `eq` is ignored outside TEST.
  - Undefined state encodings recover to IDLE.

## Timing
- Reset asserted, at any time including mid-pass: state=IDLE, `cnt`=`iter_q`=0, `first_done`=0. All outputs drop to 0 immediately (combinational decode of the asynchronously reset state).
- `start` sampled at edge k: CLEAR in cycle k+1, LOAD k+2, TEST k+3.
- `eq`=1 at the first TEST: DONE at k+4.
- Each iteration takes 2 cycles. One pass is 2 + 2·`iter_q` cycles (LOAD, TEST, then the OP pairs).
- STICKY_DONE=0: `done` is a 1-cycle pulse, and a new `start` is accepted in the IDLE cycle that follows.

## Structure
- Package `ctrl_seq_pkg`:
  - State encoding enum.
  - ALU op constants: ALU_PASS=0, ALU_OP1=1, ALU_OP2=2, ALU_FIN=3.
  - B-select constants: BSEL_REG=0, BSEL_DATA=1, BSEL_ALU=2.
- Sub-module `ctrl_seq_cnt`: ITERW-bit down-counter with load, dec and `is_one`/`is_zero` flags.
- Top level: state register, next-state logic, `first_done` flag, output decode.

## Test plan
All scenarios use NREG=3 and SELW=2.
- Reset mid-OP_B (`iter_cnt`=5): all outputs 0 within the reset-low cycle; after release, `busy`=0 and the block is in IDLE.
- `start`, `iter_cnt`=0, `eq`=1: `resReg`=3'b111 at k+1, `wen`=3'b111 with `datasel`=1 at k+2, `done`=1 at k+4, `wen`=3'b111 only at k+4.
- `iter_cnt`=2, `eq`=0 for the first TEST then 1: OP_A/OP_B at k+4..k+7, `wen`=3'b100 at k+5 and k+7, LOAD at k+8, DONE at k+10.
- STICKY_DONE=0: `done` pulses exactly 1 cycle; a second `start` in the following cycle gives CLEAR one cycle later.
- `start` pulsed during TEST and `iter_cnt` changed mid-run: sequence unchanged and the iteration count stays at the captured value.
- `iter_cnt`=15, `eq`=0 for one pass: exactly 15 `wen`=3'b100 pulses before the next LOAD.
